fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the fetch-stage state encoding.
package riscv_pkg;

    // addi x0, x0, 0 -- the bubble placed in IF/ID when nothing valid is there
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, shared with the control decoder
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, else bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    // A stall only needs to protect a real instruction; an empty slot may take
    // a delivery, which is observably identical to holding a bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= RESET_PC;
            pc4   <= RESET_PC + 32'd4;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (stall && valid) begin
            valid <= valid;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
            pc4   <= pc_in + 32'd4;
        end else begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem handshake, skid buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  skid;
    logic [31:0]  redir_pc;
    logic [31:0]  ld_instr;
    logic         ld;
    logic         cap;

    assign redir_pc  = redirect_pc & ~32'h3;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, next PC, and what (if anything) is delivered to IF/ID
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ld        = 1'b0;
        ld_instr  = imem_rdata;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) pc_nxt = redir_pc;
            end
            REQ: begin
                // A redirect after acceptance leaves a stale response in flight
                if (imem_ready) state_nxt = redirect ? DROP : WAIT;
                if (redirect)   pc_nxt    = redir_pc;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_nxt    = redir_pc;
                        state_nxt = REQ;
                    end else if (stall && if_id_valid) begin
                        cap       = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        ld        = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = REQ;
                    end
                end else if (redirect) begin
                    pc_nxt    = redir_pc;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (redirect)    pc_nxt    = redir_pc;
                if (imem_rvalid) state_nxt = REQ;
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redir_pc;
                    state_nxt = REQ;
                end else if (!stall) begin
                    ld        = 1'b1;
                    ld_instr  = skid;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC register and skid buffer for a word that arrives while IF/ID is stalled
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pc   <= RESET_PC;
            skid <= NOP_INSTR;
        end else begin
            pc <= pc_nxt;
            if (cap) skid <= imem_rdata;
        end
    end

    if_id_reg #(
        .RESET_PC(RESET_PC)
    ) u_if_id (
        .clk     (CLK),
        .rst_n   (RST_n),
        .flush   (redirect),
        .stall   (stall),
        .load    (ld),
        .instr_in(ld_instr),
        .pc_in   (pc),
        .valid   (if_id_valid),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .pc4     (if_id_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-stepped memory model plus IF/ID load scoreboard.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

    // second instance: reset vector at the top of the address space
    logic        rst2_n = 1'b0;
    logic        ready2 = 1'b1;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        stall2 = 1'b0;
    logic        req2, v2;
    logic [31:0] addr2, instr2, pc2, pc42;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t mon_e;
    logic st_e = 1'b0;
    logic v_e = 1'b0;

    // memory model state
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'h0;
    int          ready_low = 0;
    int          drop_cnt = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .CLK(CLK), .RST_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .stall(stall2),
        .if_id_valid(v2), .if_id_instr(instr2),
        .if_id_pc(pc2), .if_id_pc4(pc42)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[11:0], 20'h0};
    endfunction

    // one clock: record handshake before the edge, then drive the next cycle's memory outputs
    task automatic tick();
        bit          acc, rv;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        rv  = imem_rvalid;
        @(posedge CLK);
        #1;
        if (rv) mem_busy = 0;
        if (acc) begin
            mem_busy = 1;
            mem_addr = a;
            mem_cnt  = mem_lat;
        end
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                if (drop_cnt > 0) drop_cnt--;
                else sb.push_back('{mem_addr, mem_word(mem_addr), mem_addr + 32'd4});
            end else begin
                mem_cnt--;
            end
        end
        if (ready_low > 0) begin
            imem_ready = 1'b0;
            ready_low--;
        end else begin
            imem_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        redirect = 1'b0; stall = 1'b0; redirect_pc = 32'h0;
        mem_busy = 0; mem_lat = 1; ready_low = 0; drop_cnt = 0;
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        tick();
        tick();
        sb.delete();
        RST_n = 1'b1;
    endtask

    // stop issuing, let any in-flight response land, then expect nothing outstanding
    task automatic quiesce(input string name);
        imem_ready = 1'b0;
        ready_low  = 1000;
        repeat (8) tick();
        ready_low = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected loads never reached IF/ID", name, sb.size());
        end
    endtask

    // pre-edge view of stall and IF/ID valid, so a held entry is not counted twice
    always @(posedge CLK) begin
        st_e = stall;
        v_e  = if_id_valid && RST_n;
    end

    // scoreboard: every fresh IF/ID load must match the oldest expected delivery
    always @(negedge CLK) begin
        if (RST_n && if_id_valid && !(st_e && v_e)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: load pc=%h instr=%h with nothing expected", if_id_pc, if_id_instr);
            end else begin
                mon_e = sb.pop_front();
                if (if_id_pc !== mon_e.pc || if_id_instr !== mon_e.instr || if_id_pc4 !== mon_e.pc4) begin
                    errors++;
                    $display("FAIL sb_load: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                             if_id_pc, if_id_instr, if_id_pc4, mon_e.pc, mon_e.instr, mon_e.pc4);
                end
            end
        end
    end

    task automatic test_reset();
        RST_n = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
            if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL reset: req=%b addr=%h v=%b instr=%h pc=%h pc4=%h, expected 0 0 0 %h 0 4",
                     imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, NOP);
        end
        checks++;
        if (addr2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 || req2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: addr=%h pc4=%h req=%b, expected fffffffc 0 0", addr2, pc42, req2);
        end
    endtask

    task automatic test_zero_wait();
        bit          er[5];
        logic [31:0] ea[5];
        er = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ea = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL zw_idle: req=%b, expected 0 in first cycle out of reset", imem_req);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req !== er[i] || imem_addr !== ea[i]) begin
                errors++;
                $display("FAIL zw_seq[%0d]: req=%b addr=%h, expected req=%b addr=%h", i, imem_req, imem_addr, er[i], ea[i]);
            end
            if (i == 2) begin
                checks++;
                if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0050_0093 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin
                    errors++;
                    $display("FAIL zw_first: v=%b instr=%h pc=%h pc4=%h, expected 1 00500093 0 4",
                             if_id_valid, if_id_instr, if_id_pc, if_id_pc4);
                end
            end
        end
        quiesce("zw");
    endtask

    task automatic test_ready_low();
        do_reset();
        ready_low = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
                errors++;
                $display("FAIL rdy_hold[%0d]: req=%b addr=%h v=%b instr=%h, expected 1 0 0 %h",
                         i, imem_req, imem_addr, if_id_valid, if_id_instr, NOP);
            end
        end
        repeat (3) tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin
            errors++;
            $display("FAIL rdy_load: v=%b pc=%h, expected 1 0", if_id_valid, if_id_pc);
        end
        quiesce("rdy");
    endtask

    task automatic test_redirect_wait();
        do_reset();
        repeat (3) tick();
        mem_lat = 3;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        drop_cnt    = 1;
        tick();
        redirect = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rw_flush: v=%b instr=%h req=%b addr=%h, expected 0 %h 0 00000100",
                     if_id_valid, if_id_instr, imem_req, imem_addr, NOP);
        end
        mem_lat = 1;
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rw_drop: req=%b, expected 0 while stale response pending", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rw_target: req=%b addr=%h, expected 1 00000100", imem_req, imem_addr);
        end
        repeat (2) tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
            errors++;
            $display("FAIL rw_load: v=%b pc=%h, expected 1 00000100", if_id_valid, if_id_pc);
        end
        quiesce("rw");
    endtask

    task automatic test_stall_hold();
        do_reset();
        repeat (7) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL st_hold[%0d]: v=%b pc=%h req=%b, expected 1 00000008 0", i, if_id_valid, if_id_pc, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC || if_id_pc4 !== 32'h10 || if_id_instr !== mem_word(32'hC) ||
            imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL st_release: v=%b pc=%h pc4=%h instr=%h req=%b addr=%h, expected 1 c 10 %h 1 10",
                     if_id_valid, if_id_pc, if_id_pc4, if_id_instr, imem_req, imem_addr, mem_word(32'hC));
        end
        quiesce("st");
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        repeat (3) tick();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        drop_cnt    = 1;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fs_flush: v=%b instr=%h pc=%h req=%b, expected 0 %h 0 0",
                     if_id_valid, if_id_instr, if_id_pc, imem_req, NOP);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL fs_target: req=%b addr=%h, expected 1 00000200", imem_req, imem_addr);
        end
        repeat (2) tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin
            errors++;
            $display("FAIL fs_load: v=%b pc=%h, expected 1 00000200", if_id_valid, if_id_pc);
        end
        quiesce("fs");
    endtask

    task automatic test_wrap();
        RST_n = 1'b0;
        @(posedge CLK);
        #1;
        rst2_n = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req1: req=%b addr=%h, expected 1 fffffffc", req2, addr2);
        end
        @(posedge CLK);
        #1;
        rvalid2 = 1'b1;
        rdata2  = 32'h0050_0093;
        @(posedge CLK);
        #1;
        rvalid2 = 1'b0;
        checks++;
        if (req2 !== 1'b1 || addr2 !== 32'h0 || v2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc42 !== 32'h0 ||
            instr2 !== 32'h0050_0093) begin
            errors++;
            $display("FAIL wrap_load: req=%b addr=%h v=%b pc=%h pc4=%h instr=%h, expected 1 0 1 fffffffc 0 00500093",
                     req2, addr2, v2, pc2, pc42, instr2);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_ready_low();
        test_redirect_wait();
        test_stall_hold();
        test_flush_over_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
